// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, counter widths
// and default timing parameters.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        LOAD     = 3'd2,
        START    = 3'd3,
        WAIT_ACK = 3'd4,
        WAIT_TX  = 3'd5,
        GAP      = 3'd6
    } state_t;

    localparam int CNT_W      = 8;
    localparam int BYTE_CNT_W = 16;

    localparam logic [CNT_W-1:0] GAP_CYCLES_DEF  = 8'd16;
    localparam logic [CNT_W-1:0] ACK_TIMEOUT_DEF = 8'd8;

endpackage

// File: rtl/uart_tx_scheduler.sv
// Pops bytes from a registered-read FIFO and hands them one at a time to a UART
// transmitter, with acknowledge timeout and a fixed inter-frame gap.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter logic [CNT_W-1:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [7:0]            fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_n_re_o,
    input  logic                  tx_busy_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_start_o,
    output logic                  busy_o,
    output logic [BYTE_CNT_W-1:0] byte_cnt_o,
    output logic                  ack_err_o
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             frame_done;
    logic             ack_timeout;

    always_comb begin
        state_nx    = state;
        frame_done  = 1'b0;
        ack_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (en_i && !fifo_empty_i && !tx_busy_i) state_nx = READ;
            end
            READ:  state_nx = LOAD;
            LOAD:  state_nx = START;
            START: state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy_i) begin
                    state_nx = WAIT_TX;
                end else if (cnt >= ACK_TIMEOUT - 8'd1) begin
                    ack_timeout = 1'b1;
                    state_nx    = (GAP_CYCLES == '0) ? IDLE : GAP;
                end
            end
            WAIT_TX: begin
                if (!tx_busy_i) begin
                    frame_done = 1'b1;
                    state_nx   = (GAP_CYCLES == '0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt >= GAP_CYCLES - 8'd1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with READ/START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            fifo_n_re_o <= 1'b1;
            tx_start_o  <= 1'b0;
            tx_data_o   <= '0;
            byte_cnt_o  <= '0;
            ack_err_o   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 8'd1;
            end
            fifo_n_re_o <= (state_nx != READ);
            tx_start_o  <= (state_nx == START);
            if (state == LOAD) tx_data_o <= fifo_data_i;
            if (frame_done)    byte_cnt_o <= byte_cnt_o + 16'd1;
            if (ack_timeout)   ack_err_o <= 1'b1;
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: channel 0 uses default timing, channel 1
// uses GAP_CYCLES=0; FIFO and transmitter are small behavioural models.
module tb_uart_tx_scheduler;

    localparam int NCH = 2;

    typedef struct packed {
        logic [0:0] ch;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        en_i         [NCH];
    logic        fifo_empty_i [NCH];
    logic        fifo_n_re_o  [NCH];
    logic        tx_busy_i    [NCH] = '{default: 1'b0};
    logic        tx_start_o   [NCH];
    logic        busy_o       [NCH];
    logic        ack_err_o    [NCH];
    logic [7:0]  fifo_data_i  [NCH];
    logic [7:0]  tx_data_o    [NCH];
    logic [15:0] byte_cnt_o   [NCH];

    logic [7:0] fmem [NCH][16];
    int         frd  [NCH] = '{default: 0};
    int         fwr  [NCH] = '{default: 0};
    logic       ack_en    [NCH];
    int         frame_len [NCH];
    int         tcnt      [NCH] = '{default: 0};

    int         n_reads   [NCH] = '{default: 0};
    int         n_starts  [NCH] = '{default: 0};
    int         n_falls   [NCH] = '{default: 0};
    int         read_cyc  [NCH] = '{default: 0};
    int         start_cyc [NCH] = '{default: 0};
    int         fall_cyc  [NCH] = '{default: 0};
    logic       prev_busy [NCH] = '{default: 1'b0};
    logic [7:0] start_data[NCH] = '{default: 8'h00};

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler dut0 (
        .clk(clk), .rst(rst), .en_i(en_i[0]), .fifo_data_i(fifo_data_i[0]),
        .fifo_empty_i(fifo_empty_i[0]), .fifo_n_re_o(fifo_n_re_o[0]), .tx_busy_i(tx_busy_i[0]),
        .tx_data_o(tx_data_o[0]), .tx_start_o(tx_start_o[0]), .busy_o(busy_o[0]),
        .byte_cnt_o(byte_cnt_o[0]), .ack_err_o(ack_err_o[0])
    );

    uart_tx_scheduler #(.GAP_CYCLES(8'd0)) dut1 (
        .clk(clk), .rst(rst), .en_i(en_i[1]), .fifo_data_i(fifo_data_i[1]),
        .fifo_empty_i(fifo_empty_i[1]), .fifo_n_re_o(fifo_n_re_o[1]), .tx_busy_i(tx_busy_i[1]),
        .tx_data_o(tx_data_o[1]), .tx_start_o(tx_start_o[1]), .busy_o(busy_o[1]),
        .byte_cnt_o(byte_cnt_o[1]), .ack_err_o(ack_err_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign fifo_empty_i[c] = (frd[c] == fwr[c]);

        // FIFO with registered read data
        always @(posedge clk) begin
            if (!fifo_n_re_o[c] && frd[c] != fwr[c]) begin
                fifo_data_i[c] <= fmem[c][frd[c] % 16];
                frd[c]         <= frd[c] + 1;
            end
        end

        // Transmitter: busy from the clock after the start pulse for frame_len clocks
        always @(posedge clk) begin
            if (tx_start_o[c] && ack_en[c]) begin
                tx_busy_i[c] <= 1'b1;
                tcnt[c]      <= frame_len[c];
            end else if (tcnt[c] > 1) begin
                tcnt[c] <= tcnt[c] - 1;
            end else if (tcnt[c] == 1) begin
                tcnt[c]      <= 0;
                tx_busy_i[c] <= 1'b0;
            end
        end

        always @(negedge clk) begin
            exp_t e;
            if (rst && !fifo_n_re_o[c]) begin
                n_reads[c]++;
                read_cyc[c] = cyc;
            end
            if (rst && tx_start_o[c]) begin
                n_starts[c]++;
                start_cyc[c]  = cyc;
                start_data[c] = tx_data_o[c];
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_start", {24'h0, tx_data_o[c]}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_channel", {31'h0, e.ch}, c);
                    check("sb_tx_data", {24'h0, tx_data_o[c]}, {24'h0, e.data});
                end
            end
            if (busy_o[c] && tx_busy_i[c] && tx_data_o[c] !== start_data[c]) begin
                errors++;
                $display("FAIL tx_data_hold ch%0d: got 0x%0h, expected 0x%0h", c, tx_data_o[c], start_data[c]);
            end
            if (prev_busy[c] && !tx_busy_i[c]) begin
                n_falls[c]++;
                fall_cyc[c] = cyc;
            end
            prev_busy[c] = tx_busy_i[c];
        end
    end

    function automatic int get_count(input int kind, input int c);
        case (kind)
            0:       return n_reads[c];
            1:       return n_starts[c];
            default: return n_falls[c];
        endcase
    endfunction

    // kind: 0 = read strobes, 1 = start pulses, 2 = transmitter busy falls
    task automatic wait_count(input int kind, input int c, input int n, input int budget, input string name);
        int k = 0;
        while (get_count(kind, c) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (get_count(kind, c) < n) begin
            checks++;
            errors++;
            $display("FAIL %s: wait expired with %0d events, expected %0d", name, get_count(kind, c), n);
        end
    endtask

    task automatic wait_busy_low(input int c, input int budget, input string name);
        int k = 0;
        while (busy_o[c] && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy_o[c]) begin
            checks++;
            errors++;
            $display("FAIL %s: busy_o still 1 after %0d clocks, expected 0", name, budget);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [7:0] b, input bit expect_tx);
        fmem[c][fwr[c] % 16] = b;
        fwr[c]++;
        if (expect_tx) exp_q.push_back('{ch: c[0], data: b});
    endtask

    task automatic expect_only(input int c, input logic [7:0] b);
        exp_q.push_back('{ch: c[0], data: b});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_n_re"},     {31'h0, fifo_n_re_o[0]}, 1);
        check({tag, "_start"},    {31'h0, tx_start_o[0]},  0);
        check({tag, "_tx_data"},  {24'h0, tx_data_o[0]},   0);
        check({tag, "_busy"},     {31'h0, busy_o[0]},      0);
        check({tag, "_byte_cnt"}, {16'h0, byte_cnt_o[0]},  0);
        check({tag, "_ack_err"},  {31'h0, ack_err_o[0]},   0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time 200000, expected completion earlier");
        $fatal(1, "global timeout");
    end

    initial begin
        int t0;
        rst       = 1'b0;
        en_i      = '{default: 1'b0};
        ack_en    = '{default: 1'b1};
        frame_len = '{100, 10};
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single byte: strobe one clock after the inputs qualify, start three clocks after
        repeat (2) @(negedge clk);
        push(0, 8'hA5, 1'b1);
        en_i[0] = 1'b1;
        t0 = cyc;
        wait_count(1, 0, 1, 20, "single_start_wait");
        check("single_read_latency",  read_cyc[0] - t0, 1);
        check("single_start_latency", start_cyc[0] - t0, 3);
        check("single_read_count",    n_reads[0], 1);
        wait_count(2, 0, 1, 200, "single_busy_fall_wait");
        wait_busy_low(0, 40, "single_gap_wait");
        // 16 gap clocks begin at the edge that first samples tx_busy_i low
        check("single_gap_length", cyc - fall_cyc[0], 17);
        check("single_byte_cnt",   byte_cnt_o[0], 1);

        // Burst of four bytes
        frame_len[0] = 10;
        for (int i = 1; i <= 4; i++) push(0, i[7:0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_count(1, 0, 2 + i, 100, "burst_start_wait");
            if (i > 0) check("burst_gap_min16", (start_cyc[0] - fall_cyc[0]) >= 16, 1);
        end
        wait_count(2, 0, 5, 100, "burst_fall_wait");
        wait_busy_low(0, 40, "burst_idle_wait");
        check("burst_reads",    n_reads[0],    5);
        check("burst_starts",   n_starts[0],   5);
        check("burst_byte_cnt", byte_cnt_o[0], 5);

        // Acknowledge timeout, then re-arbitration with a responsive transmitter
        ack_en[0] = 1'b0;
        push(0, 8'h3C, 1'b1);
        wait_count(1, 0, 6, 30, "timeout_start_wait");
        t0 = start_cyc[0];
        wait_to(t0 + 8);
        check("timeout_err_early", ack_err_o[0], 0);
        wait_to(t0 + 9);
        check("timeout_err_set",  ack_err_o[0],  1);
        check("timeout_byte_cnt", byte_cnt_o[0], 5);
        ack_en[0] = 1'b1;
        push(0, 8'h5A, 1'b1);
        wait_count(1, 0, 7, 60, "rearb_start_wait");
        wait_count(2, 0, 6, 60, "rearb_fall_wait");
        wait_busy_low(0, 40, "rearb_idle_wait");
        check("rearb_byte_cnt",   byte_cnt_o[0], 6);
        check("rearb_err_sticky", ack_err_o[0],  1);

        // Enable drop during the read: only the in-flight byte completes
        push(0, 8'h11, 1'b1);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b0);
        wait_count(0, 0, 8, 20, "endrop_read_wait");
        en_i[0] = 1'b0;
        wait_count(2, 0, 7, 60, "endrop_fall_wait");
        wait_busy_low(0, 40, "endrop_idle_wait");
        repeat (30) @(negedge clk);
        check("endrop_reads",    n_reads[0],    8);
        check("endrop_starts",   n_starts[0],   8);
        check("endrop_byte_cnt", byte_cnt_o[0], 7);

        // Asynchronous reset while the transmitter is shifting
        frame_len[0] = 100;
        expect_only(0, 8'h22);
        en_i[0] = 1'b1;
        wait_count(1, 0, 9, 30, "rst_start_wait");
        repeat (6) @(negedge clk);
        check("rst_in_flight", busy_o[0], 1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_async");
        en_i[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        check("rst_no_start", n_starts[0], 9);
        check("rst_no_read",  n_reads[0],  9);
        expect_only(0, 8'h33);
        en_i[0] = 1'b1;
        wait_count(1, 0, 10, 30, "rst_requal_start_wait");
        wait_count(2, 0, 9, 200, "rst_requal_fall_wait");
        wait_busy_low(0, 40, "rst_requal_idle_wait");
        check("rst_requal_byte_cnt", byte_cnt_o[0], 1);

        // GAP_CYCLES=0: counter wrap and back-to-back read
        @(negedge clk);
        force dut1.byte_cnt_o = 16'hFFFF;
        #1 release dut1.byte_cnt_o;
        check("wrap_preload", byte_cnt_o[1], 16'hFFFF);
        push(1, 8'h7E, 1'b1);
        push(1, 8'h81, 1'b1);
        en_i[1] = 1'b1;
        wait_count(1, 1, 1, 20, "wrap_start_wait");
        wait_count(2, 1, 1, 40, "wrap_fall_wait");
        wait_count(0, 1, 2, 10, "wrap_read2_wait");
        check("nogap_read_latency", read_cyc[1] - fall_cyc[1], 2);
        check("wrap_byte_cnt",      byte_cnt_o[1], 0);
        wait_count(1, 1, 2, 20, "nogap_start2_wait");
        wait_count(2, 1, 2, 40, "nogap_fall2_wait");
        wait_busy_low(1, 10, "nogap_idle_wait");
        check("nogap_byte_cnt", byte_cnt_o[1], 1);
        check("nogap_ack_err",  ack_err_o[1],  0);
        check("sb_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 8'd16: idle clocks inserted after each frame completes before the next FIFO read; legal range 0..255.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 8'd8: maximum clocks to wait for tx_busy_i to rise after tx_start_o; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: system clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en_i, input, 1: high permits new FIFO reads.
REQ-006 SHALL have port fifo_data_i, input, 8: registered FIFO read data, valid the clock after a sampled read strobe.
REQ-007 SHALL have port fifo_empty_i, input, 1: FIFO empty flag, active-high.
REQ-008 SHALL have port fifo_n_re_o, output, 1: FIFO read strobe, active-low, registered.
REQ-009 SHALL have port tx_busy_i, input, 1: transmitter shifting a frame.
REQ-010 SHALL have port tx_data_o, output, 8: byte handed to the transmitter.
REQ-011 SHALL have port tx_start_o, output, 1: one-clock start pulse to the transmitter.
REQ-012 SHALL have port busy_o, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port byte_cnt_o, output, 16: count of bytes whose frames completed.
REQ-014 SHALL have port ack_err_o, output, 1: sticky flag, set on transmitter acknowledge timeout.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, LOAD, START, WAIT_ACK, WAIT_TX and GAP.
REQ-016 SHALL go IDLE->READ when en_i=1, fifo_empty_i=0 and tx_busy_i=0 are all sampled true; otherwise it SHALL stay in IDLE.
REQ-017 SHALL drive fifo_n_re_o=0 for exactly one clock, in READ only, and SHALL go READ->LOAD unconditionally.
REQ-018 SHALL latch fifo_data_i into tx_data_o at the end of LOAD and go to START.
REQ-019 SHALL drive tx_start_o=1 for exactly one clock, in START only, and go to WAIT_ACK; latency from the qualifying IDLE edge to tx_start_o=1 SHALL be 3 clocks.
REQ-020 SHALL go WAIT_ACK->WAIT_TX on tx_busy_i=1; if ACK_TIMEOUT clocks elapse without it, SHALL set ack_err_o and go to GAP without incrementing byte_cnt_o.
REQ-021 SHALL go WAIT_TX->GAP on tx_busy_i=0 and increment byte_cnt_o by 1 on that transition, wrapping 16'hFFFF->16'h0000.
REQ-022 SHALL stay in GAP for GAP_CYCLES clocks, then go to IDLE; with GAP_CYCLES=0 it SHALL go WAIT_TX->IDLE directly.
REQ-023 SHALL hold tx_data_o stable from the end of LOAD until the next LOAD.
REQ-024 SHALL let en_i deassertion after IDLE complete the in-flight byte, with no further read issued.
REQ-025 SHALL ignore fifo_empty_i outside IDLE; the FIFO is guaranteed non-empty at the READ strobe because it was checked at the IDLE edge and there is a single reader.
REQ-026 SHALL perform at most one FIFO read per frame and never assert fifo_n_re_o while tx_busy_i=1 is sampled in IDLE.
REQ-027 SHALL implement the gap and timeout counters as 8 bits, saturating, and clear them on state entry.

Reset
REQ-028 SHALL on rst=0 go immediately to IDLE with fifo_n_re_o=1, tx_start_o=0, tx_data_o=8'h00, busy_o=0, byte_cnt_o=16'h0000, ack_err_o=0 and counters=0.
REQ-029 SHALL abandon an in-flight byte on reset mid-operation, emitting no further strobe; a byte already popped is lost by design.
REQ-030 SHALL clear ack_err_o only by reset.

Structure
REQ-031 SHALL place the state encoding (3-bit), the counter widths and the default GAP_CYCLES/ACK_TIMEOUT values in shared package uart_ctrl_pkg.
REQ-032 SHALL be a single module with no sub-modules, with gap and timeout counting sharing one counter register.

Verification
REQ-033 SHALL verify single byte: FIFO holds 8'hA5, en_i=1, transmitter raises busy 1 clock after start and holds it 100 clocks -> one n_re pulse, tx_start_o 3 clocks later, tx_data_o=8'hA5, byte_cnt_o=1, busy_o low 16 clocks after busy falls.
REQ-034 SHALL verify burst: 4 bytes 01,02,03,04 queued -> exactly 4 read pulses and 4 start pulses in order, each start ≥16 clocks after the prior frame ends, byte_cnt_o=4.
REQ-035 SHALL verify timeout: tx_busy_i tied 0 -> ack_err_o=1 at 8 clocks after start, byte_cnt_o unchanged, FSM returns to IDLE and re-arbitrates.
REQ-036 SHALL verify enable drop: en_i=0 one clock after READ with 3 bytes queued -> the current byte completes, no further fifo_n_re_o pulses, byte_cnt_o=1.
REQ-037 SHALL verify reset in WAIT_TX: rst=0 asynchronously -> all outputs at reset values within the same clock, no tx_start_o pulse after release until new qualification.
REQ-038 SHALL verify wrap/GAP_CYCLES=0: preload byte_cnt_o to 16'hFFFF via a forced bench value -> one frame yields 16'h0000, and the next read occurs on the clock after busy falls.
